accel_apb_slv: RTL and testbench
================================

Name: accel_apb_slv

Overview:
- Generic APB responder for bus1 peripherals: terminates APB setup/access phases from the AXI-to-APB bridge and converts them into a simple single-beat req/resp interface toward device register logic.
- Adds wait states until the device responds; a programmable timeout guarantees termination.
- Emits the slave PnP descriptor from the interconnect map info.
- Instantiated once inside every bus1 APB peripheral.

Parameters:
vid, VENDOR_OPTIMITECH, PnP vendor ID reported in o_cfg
did, 16'h0, PnP device ID reported in o_cfg
timeout_cycles, 64, cycles allowed in Request+WaitResp before forced error; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock, synchronous, active-high (fixed)
i_mapinfo  in  mapinfo_type  base/end address of this slave
o_cfg  out  dev_config_type  PnP descriptor (combinational from i_mapinfo, vid, did; descrtype=PNP_CFG_TYPE_SLAVE)
i_apbi  in  apb_in_type  APB request (paddr 32, pwrite, pwdata 32, pstrb 4, pselx, penable, pprot)
o_apbo  out  apb_out_type  APB response (pready, prdata 32, pslverr)
o_req_valid  out  1  device request valid
o_req_addr  out  32  paddr minus i_mapinfo.addr_start[31:0] (modulo 2^32)
o_req_write  out  1  1 = write
o_req_wdata  out  32  write data
o_req_wstrb  out  4  byte strobes (forced 0 on reads)
i_req_ready  in  1  device accepts request
i_resp_valid  in  1  device response valid
i_resp_rdata  in  32  read data
i_resp_err  in  1  device error

Behaviour:
- Registers: state, req_addr, req_write, req_wdata, req_wstrb, resp_rdata, resp_err, tmo_cnt (clog2(timeout_cycles+1) bits, min 1).
- Reset (i_rst=1 at clock edge): state=Idle; all registers 0. Outputs during reset and after: o_apbo.pready=0, prdata=0, pslverr=0, o_req_valid=0, o_req_addr/wdata/wstrb/write=0. Reset mid-transfer discards the transfer; no pready issued.
- Outputs are registered-state decoded only; no combinational path from i_apbi to o_apbo.
- States:
  - Idle: pready=0. If pselx=1 and penable=0 (setup phase), latch paddr offset, pwrite, pwdata, pstrb (0 if read), clear tmo_cnt, go to Request. pselx=1 with penable=1 while Idle (protocol error) is ignored.
  - Request: o_req_valid=1 with latched fields. If i_req_ready=1, go to WaitResp. i_resp_valid is ignored in this state.
  - WaitResp: o_req_valid=0. If i_resp_valid=1, latch i_resp_rdata and i_resp_err, go to Resp.
  - Resp: pready=1, prdata=resp_rdata, pslverr=resp_err, held for exactly one cycle; go to Idle next cycle.
- Timeout: tmo_cnt increments each cycle in Request and WaitResp.
  - If timeout_cycles!=0 and tmo_cnt==timeout_cycles-1 with no valid transition that cycle, load resp_rdata=32'hFFFFFFFF and resp_err=1, go to Resp.
  - A valid ready/resp in the same cycle as expiry wins over the timeout.
- Abort: pselx=0 while in Request or WaitResp forces Idle. A late i_resp_valid in Idle is dropped.
- Latency: setup at T0; access phase begins T1 with req_valid=1. With i_req_ready=1 at T1 and i_resp_valid=1 at T2, pready=1 at T3, giving a 4-cycle APB transfer (2 wait states minimum).
- Reads with pslverr: prdata carries whatever the device returned.
- pprot is ignored.
- Back-to-back: a new setup is accepted in the Idle cycle directly after Resp.

Decomposition:
- New package accel_apb_slv_pkg holds:
  - state enum (State_Idle, State_Request, State_WaitResp, State_Resp)
  - accel_apb_slv_registers struct
  - accel_apb_slv_r_reset constant
- apb_in_type, apb_out_type, mapinfo_type and dev_config_type come from the existing amba/pnp packages.
- No sub-module.
- Structure: single comb process plus one synchronous always_ff that loads the reset constant when i_rst=1.

Test Plan:
- Write paddr=base+0x10, pwdata=0xA5A5_1234, pstrb=0xF; i_req_ready=1 immediately, i_resp_valid next cycle -> o_req_addr=0x10, o_req_wdata=0xA5A5_1234, o_req_wstrb=0xF; pready=1 exactly 3 cycles after setup; pslverr=0.
- Read base+0x4; device holds i_req_ready=0 for 5 cycles, then responds rdata=0xDEADBEEF, err=1 -> o_req_wstrb=0; o_req_valid held high all 5 cycles; prdata=0xDEADBEEF, pslverr=1 for one cycle.
- timeout_cycles=8, device never responds -> pready at setup+9 (Request entered at setup+1, 8 counted cycles, Resp state); prdata=0xFFFFFFFF, pslverr=1; returns to Idle.
- Response coincident with the timeout-expiry cycle -> device data returned, pslverr=i_resp_err.
- i_rst=1 asserted while in WaitResp -> next cycle state=Idle, o_req_valid=0, pready=0; a following transfer completes normally.
- pselx dropped during Request -> Idle, no pready; a stray i_resp_valid afterwards does not produce pready.

Source files
------------

// File: rtl/accel_apb_slv_pkg.sv
// State encoding, register bundle and reset value for the generic APB
// responder that fronts every bus1 peripheral.
package accel_apb_slv_pkg;

    typedef enum logic [1:0] {
        State_Idle     = 2'd0,
        State_Request  = 2'd1,
        State_WaitResp = 2'd2,
        State_Resp     = 2'd3
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [31:0] req_addr;
        logic        req_write;
        logic [31:0] req_wdata;
        logic [3:0]  req_wstrb;
        logic [31:0] resp_rdata;
        logic        resp_err;
    } accel_apb_slv_registers;

    localparam accel_apb_slv_registers accel_apb_slv_r_reset = '{
        state:      State_Idle,
        req_addr:   32'h0,
        req_write:  1'b0,
        req_wdata:  32'h0,
        req_wstrb:  4'h0,
        resp_rdata: 32'h0,
        resp_err:   1'b0
    };

    // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
    function automatic int tmo_width(input int cycles);
        return (cycles <= 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/amba_pkg.sv
// Shared bus1 interconnect types: APB request/response, slave address map
// entry and the plug-and-play descriptor emitted by every slave.
package amba_pkg;

    localparam logic [15:0] VENDOR_OPTIMITECH  = 16'h00F1;
    localparam logic [1:0]  PNP_CFG_TYPE_SLAVE = 2'd2;

    typedef struct packed {
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pselx;
        logic        penable;
        logic [2:0]  pprot;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;

    typedef struct packed {
        logic [63:0] addr_start;
        logic [63:0] addr_end;
    } mapinfo_type;

    typedef struct packed {
        logic [1:0]  descrtype;
        logic [15:0] vid;
        logic [15:0] did;
        logic [63:0] addr_start;
        logic [63:0] addr_end;
    } dev_config_type;

endpackage

// File: rtl/accel_apb_slv.sv
// APB responder: turns an APB setup/access into one req/resp beat toward the
// device, inserting wait states until it answers or the timeout fires.
module accel_apb_slv
    import amba_pkg::*;
    import accel_apb_slv_pkg::*;
#(
    parameter logic [15:0] vid            = VENDOR_OPTIMITECH,
    parameter logic [15:0] did            = 16'h0,
    parameter int          timeout_cycles = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  mapinfo_type    i_mapinfo,
    output dev_config_type o_cfg,
    input  apb_in_type     i_apbi,
    output apb_out_type    o_apbo,
    output logic           o_req_valid,
    output logic [31:0]    o_req_addr,
    output logic           o_req_write,
    output logic [31:0]    o_req_wdata,
    output logic [3:0]     o_req_wstrb,
    input  logic           i_req_ready,
    input  logic           i_resp_valid,
    input  logic [31:0]    i_resp_rdata,
    input  logic           i_resp_err
);

    localparam int TMO_W = tmo_width(timeout_cycles);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);

    accel_apb_slv_registers r, rin;
    logic [TMO_W-1:0]       tmo_cnt, tmo_nxt;
    logic                   tmo_expired;
    logic                   unused_pprot;

    assign unused_pprot = ^i_apbi.pprot;
    assign tmo_expired  = (timeout_cycles != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        rin     = r;
        tmo_nxt = tmo_cnt;
        unique case (r.state)
            State_Idle: begin
                // Only a clean setup phase starts a transfer; a stray access
                // phase without a preceding setup is dropped.
                if (i_apbi.pselx && !i_apbi.penable) begin
                    rin.req_addr  = i_apbi.paddr - i_mapinfo.addr_start[31:0];
                    rin.req_write = i_apbi.pwrite;
                    rin.req_wdata = i_apbi.pwdata;
                    rin.req_wstrb = i_apbi.pwrite ? i_apbi.pstrb : 4'h0;
                    tmo_nxt       = '0;
                    rin.state     = State_Request;
                end
            end
            State_Request: begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
                if (!i_apbi.pselx) begin
                    rin.state = State_Idle;
                end else if (i_req_ready) begin
                    rin.state = State_WaitResp;
                end else if (tmo_expired) begin
                    rin.resp_rdata = 32'hFFFF_FFFF;
                    rin.resp_err   = 1'b1;
                    rin.state      = State_Resp;
                end
            end
            State_WaitResp: begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
                // A response landing on the expiry cycle beats the timeout.
                if (!i_apbi.pselx) begin
                    rin.state = State_Idle;
                end else if (i_resp_valid) begin
                    rin.resp_rdata = i_resp_rdata;
                    rin.resp_err   = i_resp_err;
                    rin.state      = State_Resp;
                end else if (tmo_expired) begin
                    rin.resp_rdata = 32'hFFFF_FFFF;
                    rin.resp_err   = 1'b1;
                    rin.state      = State_Resp;
                end
            end
            State_Resp: begin
                rin.state = State_Idle;
            end
            default: begin
                rin.state = State_Idle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r       <= accel_apb_slv_r_reset;
            tmo_cnt <= '0;
        end else begin
            r       <= rin;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Everything below decodes registered state only.
    assign o_apbo.pready  = (r.state == State_Resp);
    assign o_apbo.prdata  = (r.state == State_Resp) ? r.resp_rdata : 32'h0;
    assign o_apbo.pslverr = (r.state == State_Resp) ? r.resp_err : 1'b0;

    assign o_req_valid = (r.state == State_Request);
    assign o_req_addr  = r.req_addr;
    assign o_req_write = r.req_write;
    assign o_req_wdata = r.req_wdata;
    assign o_req_wstrb = r.req_wstrb;

    assign o_cfg.descrtype  = PNP_CFG_TYPE_SLAVE;
    assign o_cfg.vid        = vid;
    assign o_cfg.did        = did;
    assign o_cfg.addr_start = i_mapinfo.addr_start;
    assign o_cfg.addr_end   = i_mapinfo.addr_end;

endmodule

// File: tb/tb_accel_apb_slv.sv
// Directed bench for accel_apb_slv: fast write, stalled read, timeout,
// response-on-expiry, mid-transfer reset, abort and back-to-back transfers.
module tb_accel_apb_slv;
    import amba_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic           clk;
    logic           rst;
    mapinfo_type    mapinfo;
    dev_config_type cfg;
    apb_in_type     apbi;
    apb_out_type    apbo;
    logic           req_valid;
    logic [31:0]    req_addr;
    logic           req_write;
    logic [31:0]    req_wdata;
    logic [3:0]     req_wstrb;
    logic           req_ready;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_err;

    int n_cmp = 0;
    int n_err = 0;

    accel_apb_slv #(
        .vid            (VENDOR_OPTIMITECH),
        .did            (16'h0A5C),
        .timeout_cycles (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mapinfo    (mapinfo),
        .o_cfg        (cfg),
        .i_apbi       (apbi),
        .o_apbo       (apbo),
        .o_req_valid  (req_valid),
        .o_req_addr   (req_addr),
        .o_req_write  (req_write),
        .o_req_wdata  (req_wdata),
        .o_req_wstrb  (req_wstrb),
        .i_req_ready  (req_ready),
        .i_resp_valid (resp_valid),
        .i_resp_rdata (resp_rdata),
        .i_resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_setup(input logic [31:0] addr, input logic write,
                             input logic [31:0] wdata, input logic [3:0] strb);
        apbi.paddr   = addr;
        apbi.pwrite  = write;
        apbi.pwdata  = wdata;
        apbi.pstrb   = strb;
        apbi.pprot   = 3'b010;
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b0;
    endtask

    task automatic apb_idle;
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
    endtask

    // Minimum-latency transfer: setup, ready at T1, response at T2, pready at T3.
    task automatic xfer_fast(input string tag, input logic [31:0] addr, input logic write,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [31:0] rdata, input logic err,
                             input logic [31:0] exp_off, input logic [3:0] exp_strb);
        apb_setup(addr, write, wdata, strb);
        tick;
        apbi.penable = 1'b1;
        req_ready    = 1'b1;
        chk({tag, ".t1_valid"}, 32'(req_valid), 32'd1);
        chk({tag, ".t1_addr"}, req_addr, exp_off);
        chk({tag, ".t1_write"}, 32'(req_write), 32'(write));
        chk({tag, ".t1_wdata"}, req_wdata, wdata);
        chk({tag, ".t1_wstrb"}, 32'(req_wstrb), 32'(exp_strb));
        chk({tag, ".t1_pready"}, 32'(apbo.pready), 32'd0);
        tick;
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = rdata;
        resp_err   = err;
        chk({tag, ".t2_valid"}, 32'(req_valid), 32'd0);
        chk({tag, ".t2_pready"}, 32'(apbo.pready), 32'd0);
        tick;
        resp_valid = 1'b0;
        chk({tag, ".t3_pready"}, 32'(apbo.pready), 32'd1);
        chk({tag, ".t3_prdata"}, apbo.prdata, rdata);
        chk({tag, ".t3_pslverr"}, 32'(apbo.pslverr), 32'(err));
        apb_idle;
        tick;
        chk({tag, ".t4_pready"}, 32'(apbo.pready), 32'd0);
        chk({tag, ".t4_prdata"}, apbo.prdata, 32'h0);
    endtask

    initial begin
        rst                = 1'b1;
        mapinfo.addr_start = 64'h0000_0000_8000_0000;
        mapinfo.addr_end   = 64'h0000_0000_8000_0FFF;
        apbi               = '0;
        req_ready          = 1'b0;
        resp_valid         = 1'b0;
        resp_rdata         = 32'h0;
        resp_err           = 1'b0;

        // Reset state and PnP descriptor
        tick;
        tick;
        chk("rst.pready", 32'(apbo.pready), 32'd0);
        chk("rst.prdata", apbo.prdata, 32'h0);
        chk("rst.pslverr", 32'(apbo.pslverr), 32'd0);
        chk("rst.req_valid", 32'(req_valid), 32'd0);
        chk("rst.req_addr", req_addr, 32'h0);
        chk("rst.req_wdata", req_wdata, 32'h0);
        chk("rst.req_wstrb", 32'(req_wstrb), 32'h0);
        chk("cfg.descrtype", 32'(cfg.descrtype), 32'd2);
        chk("cfg.vid", 32'(cfg.vid), 32'h0000_00F1);
        chk("cfg.did", 32'(cfg.did), 32'h0000_0A5C);
        chk("cfg.addr_start", cfg.addr_start[31:0], 32'h8000_0000);
        chk("cfg.addr_end", cfg.addr_end[31:0], 32'h8000_0FFF);
        rst = 1'b0;
        tick;

        // Fast write, then a read accepted in the very next Idle cycle
        xfer_fast("wr_fast", BASE + 32'h10, 1'b1, 32'hA5A5_1234, 4'hF,
                  32'h0, 1'b0, 32'h10, 4'hF);
        xfer_fast("rd_b2b", BASE + 32'h20, 1'b0, 32'h0, 4'hF,
                  32'h0BAD_F00D, 1'b0, 32'h20, 4'h0);

        // Access phase without setup in Idle is ignored
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b1;
        tick;
        chk("proto.req_valid", 32'(req_valid), 32'd0);
        apb_idle;
        tick;

        // Stalled read with device error
        apb_setup(BASE + 32'h4, 1'b0, 32'h0, 4'hF);
        tick;
        apbi.penable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rd_stall.valid", 32'(req_valid), 32'd1);
            chk("rd_stall.wstrb", 32'(req_wstrb), 32'h0);
            chk("rd_stall.addr", req_addr, 32'h4);
            chk("rd_stall.pready", 32'(apbo.pready), 32'd0);
            tick;
        end
        req_ready = 1'b1;
        chk("rd_stall.t6_valid", 32'(req_valid), 32'd1);
        tick;
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 32'hDEAD_BEEF;
        resp_err   = 1'b1;
        chk("rd_stall.t7_valid", 32'(req_valid), 32'd0);
        tick;
        resp_valid = 1'b0;
        chk("rd_stall.pready", 32'(apbo.pready), 32'd1);
        chk("rd_stall.prdata", apbo.prdata, 32'hDEAD_BEEF);
        chk("rd_stall.pslverr", 32'(apbo.pslverr), 32'd1);
        apb_idle;
        tick;
        chk("rd_stall.end_pready", 32'(apbo.pready), 32'd0);
        chk("rd_stall.end_pslverr", 32'(apbo.pslverr), 32'd0);

        // Timeout: device never answers, pready at setup+9
        apb_setup(BASE + 32'h8, 1'b1, 32'h1111_2222, 4'h3);
        tick;
        apbi.penable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("tmo.wait_pready", 32'(apbo.pready), 32'd0);
            tick;
        end
        chk("tmo.pready", 32'(apbo.pready), 32'd1);
        chk("tmo.prdata", apbo.prdata, 32'hFFFF_FFFF);
        chk("tmo.pslverr", 32'(apbo.pslverr), 32'd1);
        chk("tmo.req_valid", 32'(req_valid), 32'd0);
        apb_idle;
        tick;
        chk("tmo.idle_pready", 32'(apbo.pready), 32'd0);

        // Response arrives on the expiry cycle (setup+8) and wins
        apb_setup(BASE + 32'hC, 1'b0, 32'h0, 4'h0);
        tick;
        apbi.penable = 1'b1;
        req_ready    = 1'b1;
        tick;
        req_ready = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            chk("race.wait_pready", 32'(apbo.pready), 32'd0);
            tick;
        end
        resp_valid = 1'b1;
        resp_rdata = 32'h1234_5678;
        resp_err   = 1'b0;
        tick;
        resp_valid = 1'b0;
        chk("race.pready", 32'(apbo.pready), 32'd1);
        chk("race.prdata", apbo.prdata, 32'h1234_5678);
        chk("race.pslverr", 32'(apbo.pslverr), 32'd0);
        apb_idle;
        tick;

        // Reset while in WaitResp, then a normal transfer
        apb_setup(BASE + 32'h30, 1'b1, 32'h0000_55AA, 4'hC);
        tick;
        apbi.penable = 1'b1;
        req_ready    = 1'b1;
        tick;
        req_ready = 1'b0;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        apb_idle;
        chk("mid_rst.req_valid", 32'(req_valid), 32'd0);
        chk("mid_rst.pready", 32'(apbo.pready), 32'd0);
        chk("mid_rst.req_addr", req_addr, 32'h0);
        chk("mid_rst.req_wdata", req_wdata, 32'h0);
        tick;
        chk("mid_rst.after_pready", 32'(apbo.pready), 32'd0);
        xfer_fast("post_rst", BASE + 32'h34, 1'b1, 32'hCAFE_0001, 4'h5,
                  32'h0, 1'b1, 32'h34, 4'h5);

        // Abort in Request, then a late response must not produce pready
        apb_setup(BASE + 32'h40, 1'b1, 32'h0000_0040, 4'hF);
        tick;
        chk("abort.t1_valid", 32'(req_valid), 32'd1);
        apb_idle;
        tick;
        chk("abort.t2_valid", 32'(req_valid), 32'd0);
        chk("abort.t2_pready", 32'(apbo.pready), 32'd0);
        resp_valid = 1'b1;
        resp_rdata = 32'h0000_0077;
        tick;
        chk("abort.stray_pready", 32'(apbo.pready), 32'd0);
        resp_valid = 1'b0;
        tick;
        chk("abort.final_pready", 32'(apbo.pready), 32'd0);
        chk("abort.final_valid", 32'(req_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
